// File: rtl/bitop_pipe.sv
// Two-stage pipelined bitwise operator with op-select, running XOR accumulator,
// Hamming-distance mode, valid/ready handshakes and a saturating delivery counter.
module bitop_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    OP_XOR     = 3'b000,
    OP_AND     = 3'b001,
    OP_OR      = 3'b010,
    OP_XNOR    = 3'b011,
    OP_ACC_XOR = 3'b100,
    OP_ACC_CLR = 3'b101,
    OP_HAM     = 3'b110,
    OP_RSVD    = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] ham;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic             accept;
  logic             deliver;
  logic             s1_adv;

  // S1 may move into S2 whenever S2 is empty or is being drained this cycle.
  assign deliver  = out_valid && out_ready;
  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = rst_n && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;
  assign diff     = s1_a ^ s1_b;

  always_comb begin
    ham = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ham = ham + WIDTH'(diff[i]);
    end
  end

  // acc_next is only committed on the S1->S2 transfer, so stalls never re-apply it.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    acc_next = acc;
    case (s1_op)
      OP_XOR:     res_data = diff;
      OP_AND:     res_data = s1_a & s1_b;
      OP_OR:      res_data = s1_a | s1_b;
      OP_XNOR:    res_data = ~diff;
      OP_ACC_XOR: begin
        acc_next = acc ^ diff;
        res_data = acc_next;
      end
      OP_ACC_CLR: begin
        acc_next = '0;
        res_data = '0;
      end
      OP_HAM:     res_data = ham;
      OP_RSVD:    res_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_XOR;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_op    <= op_e'(op);
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      acc       <= '0;
      count     <= '0;
    end else begin
      if (s1_adv) begin
        out_valid <= 1'b1;
        out_data  <= res_data;
        out_err   <= res_err;
        acc       <= acc_next;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
      if (deliver && (count != {CNT_W{1'b1}})) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bitop_pipe.sv
// Scoreboard bench for bitop_pipe: a behavioural model pushes expected results on
// accept, a negedge monitor pops and compares on every output handshake.
module tb_bitop_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [2:0]  op = '0;
  logic        in_ready, out_valid, out_err;
  logic [7:0]  out_data;
  logic [15:0] count;
  logic        in_ready4, out_valid4, out_err4;
  logic [7:0]  out_data4;
  logic [3:0]  count4;

  bitop_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .count(count)
  );

  // Narrow-counter twin sees identical traffic; only its count is observed.
  bitop_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_err(out_err4), .count(count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         acc_cyc;
    bit         lat_ok;
  } exp_t;

  exp_t       sb[$];
  int         deliv_cyc[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         delivered = 0;
  int         mode0_start = 0;
  int         rdy_mode = 0;
  logic [7:0] model_acc = '0;
  bit         hold_pending = 0;
  logic [8:0] hold_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [7:0] ra, input logic [7:0] rb,
                                input logic [2:0] rop, output logic [7:0] d,
                                output logic e);
    d = 8'h00;
    e = 1'b0;
    case (rop)
      3'd0: d = ra ^ rb;
      3'd1: d = ra & rb;
      3'd2: d = ra | rb;
      3'd3: d = ~(ra ^ rb);
      3'd4: begin model_acc = model_acc ^ ra ^ rb; d = model_acc; end
      3'd5: begin model_acc = 8'h00; d = 8'h00; end
      3'd6: d = 8'($countones(ra ^ rb));
      default: e = 1'b1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_b, input logic [2:0] top,
                               input int max_wait, output int waited, output bit ok);
    exp_t       item;
    logic [7:0] d;
    logic       e;
    a = ta; b = tb_b; op = top; in_valid = 1'b1;
    waited = 0;
    ok = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        model(ta, tb_b, top, d, e);
        item.d = d;
        item.e = e;
        item.acc_cyc = cyc;
        item.lat_ok = (rdy_mode == 0) && (out_ready === 1'b1) && (cyc >= mode0_start);
        sb.push_back(item);
        ok = 1;
        break;
      end
      waited++;
      if (waited >= max_wait) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (ok) begin
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      op = 3'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic setReady(input logic r);
    rdy_mode = 0;
    out_ready = r;
    mode0_start = cyc;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) out_ready = ~out_ready;
      else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: counter tracking, stall hold stability, and in-order scoreboard compare.
  initial begin
    exp_t item;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        checkOutput("count", 32'(count), (delivered > 65535) ? 32'd65535 : 32'(delivered));
        checkOutput("count4", 32'(count4), (delivered > 15) ? 32'd15 : 32'(delivered));
        if (hold_pending) begin
          checkOutput("hold_valid", 32'(out_valid), 32'd1);
          checkOutput("hold_data", 32'({out_err, out_data}), 32'(hold_val));
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            item = sb.pop_front();
            checkOutput("out_data", 32'(out_data), 32'(item.d));
            checkOutput("out_err", 32'(out_err), 32'(item.e));
            if (item.lat_ok) checkOutput("latency", 32'(cyc - item.acc_cyc), 32'd2);
          end
          delivered++;
          deliv_cyc.push_back(cyc);
        end
        hold_pending = (out_valid === 1'b1) && (out_ready !== 1'b1);
        hold_val = {out_err, out_data};
      end else begin
        hold_pending = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    bit ok;
    int d0;
    int c0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    setReady(1'b1);
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);

    // Single XOR
    applyStimulus(8'h5A, 8'h0F, 3'b000, 50, w, ok);
    checkOutput("t1_accept", 32'(ok), 32'd1);
    drain();
    checkOutput("t1_count", 32'(count), 32'd1);

    // Back-to-back AND/OR/XNOR
    d0 = deliv_cyc.size();
    applyStimulus(8'hF0, 8'h3C, 3'b001, 50, w, ok);
    checkOutput("t2_wait0", 32'(w), 32'd0);
    applyStimulus(8'h81, 8'h18, 3'b010, 50, w, ok);
    checkOutput("t2_wait1", 32'(w), 32'd0);
    applyStimulus(8'h00, 8'hFF, 3'b011, 50, w, ok);
    checkOutput("t2_wait2", 32'(w), 32'd0);
    drain();
    checkOutput("t2_ndeliv", 32'(deliv_cyc.size() - d0), 32'd3);
    if (deliv_cyc.size() - d0 == 3) begin
      checkOutput("t2_consec1", 32'(deliv_cyc[d0+1] - deliv_cyc[d0]), 32'd1);
      checkOutput("t2_consec2", 32'(deliv_cyc[d0+2] - deliv_cyc[d0+1]), 32'd1);
    end
    checkOutput("t2_count", 32'(count), 32'd4);

    // Accumulator chain, then again with out_ready toggling
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) rdy_mode = 1;
      applyStimulus(8'h00, 8'h00, 3'b101, 50, w, ok);
      applyStimulus(8'h12, 8'h00, 3'b100, 50, w, ok);
      applyStimulus(8'h34, 8'h00, 3'b100, 50, w, ok);
      applyStimulus(8'hFF, 8'h0F, 3'b100, 50, w, ok);
      checkOutput("t3_accept", 32'(ok), 32'd1);
      drain();
    end
    setReady(1'b1);

    // Hamming, reserved op, accumulator untouched by reserved op
    applyStimulus(8'hFF, 8'h00, 3'b110, 50, w, ok);
    applyStimulus(8'hA5, 8'h5A, 3'b110, 50, w, ok);
    applyStimulus(8'h77, 8'h99, 3'b111, 50, w, ok);
    applyStimulus(8'h00, 8'h00, 3'b100, 50, w, ok);
    drain();

    // Backpressure: only two fit, outputs held, then all three drain in order
    c0 = delivered;
    setReady(1'b0);
    applyStimulus(8'h11, 8'h22, 3'b000, 50, w, ok);
    checkOutput("t5_acc0", 32'(ok), 32'd1);
    applyStimulus(8'h33, 8'h44, 3'b000, 50, w, ok);
    checkOutput("t5_acc1", 32'(ok), 32'd1);
    applyStimulus(8'h55, 8'h66, 3'b000, 6, w, ok);
    checkOutput("t5_third_blocked", 32'(ok), 32'd0);
    checkOutput("t5_in_ready", 32'(in_ready), 32'd0);
    checkOutput("t5_held_data", 32'(out_data), 32'h33);
    setReady(1'b1);
    applyStimulus(8'h55, 8'h66, 3'b000, 50, w, ok);
    checkOutput("t5_acc2", 32'(ok), 32'd1);
    drain();
    checkOutput("t5_ndeliv", 32'(delivered - c0), 32'd3);

    // Asynchronous reset with both stages full and stalled
    setReady(1'b0);
    applyStimulus(8'hAA, 8'h01, 3'b000, 50, w, ok);
    applyStimulus(8'hBB, 8'h02, 3'b100, 50, w, ok);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_out_data", 32'(out_data), 32'd0);
    checkOutput("t6_out_err", 32'(out_err), 32'd0);
    checkOutput("t6_in_ready", 32'(in_ready), 32'd0);
    checkOutput("t6_count", 32'(count), 32'd0);
    checkOutput("t6_count4", 32'(count4), 32'd0);
    sb.delete();
    deliv_cyc.delete();
    delivered = 0;
    model_acc = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    setReady(1'b1);
    #1;
    checkOutput("t6_release_ready", 32'(in_ready), 32'd1);
    applyStimulus(8'h01, 8'h02, 3'b000, 50, w, ok);
    drain();
    checkOutput("t6_count_after", 32'(count), 32'd1);
    applyStimulus(8'h00, 8'h00, 3'b100, 50, w, ok);
    drain();

    // Randomised traffic with random backpressure and bubbles
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      applyStimulus(8'($urandom), 8'($urandom), 3'($urandom), 50, w, ok);
      if (!ok) checkOutput("rand_accept", 32'(ok), 32'd1);
    end
    drain();
    setReady(1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("cnt4_saturated", 32'(count4), 32'd15);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
